// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks: scheduler state encoding,
// default timing constants and a width helper.
package uart_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_t;

    localparam int DEF_NREQ         = 4;
    localparam int DEF_CLK_DIV      = 1600;  // 50 MHz / 31250 baud
    localparam int DEF_LOCK_TIMEOUT = 320;

    // Ceiling log2, never below 1 so it can always size a vector.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running bit-period counter producing a one-clock shift strobe every
// CLK_DIV clocks; shared by the transmit and receive sides.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clock,
    input  logic reset_n,
    output logic shift
);

    localparam int CW = clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create ordering-dependent races.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            shift <= 1'b0;
        end else begin
            cnt   <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
            shift <= (cnt == CNT_LAST);
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin, packet-locked arbiter feeding one shared UART transmitter from
// NREQ byte sources, with idle-lock timeout and the transmitter's baud strobe.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NREQ         = DEF_NREQ,
    parameter int CLK_DIV      = DEF_CLK_DIV,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   data,
    input  logic [NREQ-1:0]     last,
    output logic [NREQ-1:0]     ack,
    output logic [NREQ-1:0]     grant,
    output logic [7:0]          tx_din,
    output logic                tx_load,
    input  logic                tx_ready,
    output logic                tx_shift,
    output logic                busy
);

    localparam int PW = clog2(NREQ);
    localparam int TW = clog2(LOCK_TIMEOUT + 1);
    localparam logic [NREQ-1:0] GRANT0  = NREQ'(1);
    localparam logic [PW-1:0]   PTR_MAX = PW'(NREQ - 1);
    localparam logic [TW-1:0]   TO_LIMIT = TW'(LOCK_TIMEOUT);

    sched_state_t  state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [TW-1:0] tcnt;

    logic [PW-1:0] pick;
    logic          pick_valid;
    logic [PW-1:0] owner_next;
    logic [7:0]    owner_data;
    logic          load_ok;

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud (
        .clock   (clock),
        .reset_n (reset_n),
        .shift   (tx_shift)
    );

    // First requester at or after the pointer; scanning downward lets the
    // closest one overwrite the others.
    // NOTE: every always_comb output gets a default first so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        int idx;
        idx        = 0;
        pick       = '0;
        pick_valid = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) begin
                pick       = PW'(idx);
                pick_valid = 1'b1;
            end
        end
    end

    assign owner_next = (owner == PTR_MAX) ? '0 : owner + PW'(1);
    assign owner_data = data[8*int'(owner) +: 8];
    // tx_ready only rises the clock after a load, so the load itself must block the next one.
    assign load_ok    = req[owner] && !tx_ready && !tx_load;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            tcnt    <= '0;
            ack     <= '0;
            grant   <= '0;
            tx_din  <= '0;
            tx_load <= 1'b0;
            busy    <= 1'b0;
        end else begin
            ack     <= '0;
            tx_load <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner <= pick;
                        grant <= GRANT0 << pick;
                        busy  <= 1'b1;
                        tcnt  <= '0;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (load_ok) begin
                        tx_load <= 1'b1;
                        tx_din  <= owner_data;
                        ack     <= grant;
                        tcnt    <= '0;
                        if (last[owner]) begin
                            grant <= '0;
                            busy  <= 1'b0;
                            ptr   <= owner_next;
                            state <= IDLE;
                        end
                    end else if (tcnt == TO_LIMIT) begin
                        // Owner went quiet mid-packet: release without ack.
                        grant <= '0;
                        busy  <= 1'b0;
                        ptr   <= owner_next;
                        tcnt  <= '0;
                        state <= IDLE;
                    end else if (!req[owner] && tx_shift) begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Schedules one shared 8-bit UART transmitter (holding register + shifter, 1x shift strobe) among NREQ byte sources, e.g. MIDI-out, debug, status.
- Also generates the transmitter's baud shift strobe.
- Grants are round-robin and packet-locked: a multi-byte message (e.g. 3-byte MIDI note-on) is never interleaved with another source.
- Sits between the per-function message builders and the transmitter in the codec top level.

Parameters:
- NREQ, 4: number of requesters (2..8).
- CLK_DIV, 1600: clocks per bit; 50 MHz / 31250 baud.
- LOCK_TIMEOUT, 320: shift strobes a locked grant may idle before forced release.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-source byte valid; level, held until ack
- data  in  8*NREQ  per-source byte; source i on bits [8i+7:8i]
- last  in  NREQ  byte on data[i] ends its packet; sampled with the byte
- ack  out  NREQ  one-clock pulse: source's byte was accepted
- grant  out  NREQ  one-hot current owner; all-zero when idle
- tx_din  out  8  byte to transmitter
- tx_load  out  1  one-clock load strobe to transmitter
- tx_ready  in  1  transmitter holding register full (1 = cannot accept)
- tx_shift  out  1  baud strobe to transmitter, one clock every CLK_DIV clocks
- busy  out  1  grant nonzero

Behaviour:
- Interface: one clock `clock`; reset is asynchronous and active-low (`reset_n`).
- Reset values: ack=0, grant=0, tx_din=0, tx_load=0, tx_shift=0, busy=0, baud counter=0, RR pointer=0, timeout counter=0, state=IDLE.
- All outputs are registered.
- Baud: counter runs 0..CLK_DIV-1 continuously, independent of the FSM. tx_shift=1 on the clock where counter==CLK_DIV-1. Counter wraps to 0 there.
- FSM states:
  - IDLE: grant=0. If any req, pick the first set req at or after the RR pointer (wrapping modulo NREQ). Register the one-hot grant and enter LOCKED. No load is issued in the IDLE cycle; minimum latency from req to tx_load is 2 clocks.
  - LOCKED, owner g: the load condition is req[g] && !tx_ready && !tx_load.
    - The !tx_load term blocks back-to-back loads, because tx_ready rises only one clock after the load.
    - When the condition holds: next cycle tx_load=1, tx_din=data[g], ack[g]=1, each for exactly one clock, and the timeout counter clears.
    - If last[g] was 1 with that byte: go to IDLE, grant cleared the same edge, pointer = (g+1) mod NREQ.
    - Otherwise stay in LOCKED.
  - Timeout in LOCKED: while req[g]=0, count tx_shift strobes. On reaching LOCK_TIMEOUT, force release to IDLE with pointer = (g+1) mod NREQ. No ack is issued.
- Non-owner req: ignored, never acked.
- Owner drops req after ack: a new req[g] byte continues the same packet.
- Simultaneous events:
  - tx_shift and a load in the same clock are independent.
  - A timeout and a load condition in the same clock: the load wins and the counter clears.
- Reset mid-packet: everything returns to reset values immediately. A source must restart its packet.
- tx_ready=1 for any duration: LOCKED holds with no ack and no load. The timeout does not count, because req is still high.
- Width rules:
  - Baud counter: clog2(CLK_DIV) bits.
  - Timeout counter: clog2(LOCK_TIMEOUT+1) bits, saturating.
  - RR pointer: clog2(NREQ) bits, wrapping modulo NREQ (non-power-of-2 NREQ handled explicitly).

Decomposition:
- Shared package uart_pkg: FSM state encoding (IDLE=0, LOCKED=1), default CLK_DIV/baud constants, a clog2 function.
- One natural sub-module: uart_baud_gen (counter + tx_shift strobe, parameter CLK_DIV). It is reusable by the receiver side.
- RR select stays inline.

Test Plan:
- Reset then idle: reset_n=0 for 3 clocks, release, no req → grant=0, tx_load=0. tx_shift pulses exactly every 1600 clocks (first pulse on clock 1600 after release).
- Single source: req[1]=1, data[1]=0x90 last=0, then 0x3C last=0, then 0x7F last=1, with a behavioural transmitter model → exactly 3 tx_load pulses carrying 0x90, 0x3C, 0x7F in order. ack[1] pulses 3 times, never two loads on consecutive clocks, grant returns to 0 after the third ack.
- Non-interleave: req[0] holds a 3-byte packet while req[2] is asserted from cycle 1 → all three source-0 bytes load before any source-2 byte. Grant then moves to source 2.
- Round-robin fairness: req[0..3] all continuously high with 1-byte packets (last=1) → grant order 0,1,2,3,0,...; no source gets a second grant before the others each get one.
- Backpressure: tx_ready forced 1 for 5000 clocks while req[3]=1 → no tx_load, no ack, no timeout. On tx_ready=0, load occurs 1 clock later.
- Timeout / reset: source 1 sends a non-last byte then drops req → after 320 tx_shift strobes grant clears and source 2 (pending) is granted next. Separately, reset_n pulsed low mid-packet → all outputs return to 0 asynchronously.
